// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: cause codes,
// mtvec modes, FSM encoding and the handler-address helper.
package trap_ctrl_pkg;

    localparam logic [3:0] EXC_INSN_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_INSN_FAULT     = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSN   = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [1:0] MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MODE_VECTORED = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Vectored mode only applies to interrupts; exceptions always use BASE.
    function automatic logic [31:0] handler_target(input logic [31:0] tvec,
                                                   input logic        is_irq,
                                                   input logic [3:0]  code);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (is_irq && (tvec[1:0] == MODE_VECTORED)) begin
            return base + {26'd0, code, 2'b00};
        end else begin
            return base;
        end
    endfunction

endpackage

// File: rtl/trap_ctrl_arbiter.sv
// Combinational request arbiter: exception > enabled interrupt at retire > mret.
module trap_ctrl_arbiter
    import trap_ctrl_pkg::*;
(
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic [2:0]  irq_pending_i,
    input  logic [2:0]  irq_enable_i,
    input  logic        mstatus_mie_i,
    input  logic        retire_i,
    input  logic [31:0] next_pc_i,
    input  logic        mret_i,
    output logic        take_o,
    output logic        is_irq_o,
    output logic        is_mret_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] tval_o
);

    logic [2:0] irq_act_s;
    logic       irq_ok_s;
    logic [3:0] irq_code_s;

    // Interrupt selection; bit order is {MEI, MTI, MSI}, priority MEI > MSI > MTI.
    always_comb begin
        irq_act_s = irq_pending_i & irq_enable_i;
        irq_ok_s  = retire_i & mstatus_mie_i & (|irq_act_s);
        if (irq_act_s[2]) begin
            irq_code_s = IRQ_MEI;
        end else if (irq_act_s[0]) begin
            irq_code_s = IRQ_MSI;
        end else begin
            irq_code_s = IRQ_MTI;
        end
    end

    // Final request selection and captured-value formation.
    always_comb begin
        take_o    = 1'b0;
        is_irq_o  = 1'b0;
        is_mret_o = 1'b0;
        cause_o   = 32'd0;
        epc_o     = 32'd0;
        tval_o    = 32'd0;
        if (exc_valid_i) begin
            take_o  = 1'b1;
            cause_o = {28'd0, exc_code_i};
            epc_o   = exc_pc_i;
            tval_o  = exc_tval_i;
        end else if (irq_ok_s) begin
            take_o   = 1'b1;
            is_irq_o = 1'b1;
            cause_o  = {1'b1, 27'd0, irq_code_s};
            epc_o    = next_pc_i;
        end else if (mret_i) begin
            take_o    = 1'b1;
            is_mret_o = 1'b1;
        end else begin
            take_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer beside the M-mode CSR file: accepts a trap or mret, flushes
// the pipeline for FLUSH_CYCLES, then redirects fetch to the handler or mepc.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 32'd2,
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic [2:0]  irq_pending,
    input  logic [2:0]  irq_enable,
    input  logic        mstatus_mie,
    input  logic        retire,
    input  logic [31:0] next_pc,
    input  logic        mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        trap_wr,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_tval,
    output logic        mret_wr,
    output logic        busy
);

    if ((FLUSH_CYCLES < 32'd1) || (FLUSH_CYCLES > 32'd15)) begin : g_bad_flush_cycles
        $error("trap_ctrl: FLUSH_CYCLES must be within 1..15");
    end
    if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
        $error("trap_ctrl: RESET_VEC must be word aligned");
    end

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 32'd1);

    logic        arb_take_s;
    logic        arb_is_irq_s;
    logic        arb_is_mret_s;
    logic [31:0] arb_cause_s;
    logic [31:0] arb_epc_s;
    logic [31:0] arb_tval_s;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] target_q, target_d;
    logic        trap_wr_q, trap_wr_d;
    logic        mret_wr_q, mret_wr_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    trap_ctrl_arbiter u_arbiter (
        .exc_valid_i   (exc_valid),
        .exc_code_i    (exc_code),
        .exc_pc_i      (exc_pc),
        .exc_tval_i    (exc_tval),
        .irq_pending_i (irq_pending),
        .irq_enable_i  (irq_enable),
        .mstatus_mie_i (mstatus_mie),
        .retire_i      (retire),
        .next_pc_i     (next_pc),
        .mret_i        (mret),
        .take_o        (arb_take_s),
        .is_irq_o      (arb_is_irq_s),
        .is_mret_o     (arb_is_mret_s),
        .cause_o       (arb_cause_s),
        .epc_o         (arb_epc_s),
        .tval_o        (arb_tval_s)
    );

    // Next-state, capture and output-strobe logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        tval_d    = tval_q;
        target_d  = target_q;
        trap_wr_d = 1'b0;
        mret_wr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_take_s) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                    if (arb_is_mret_s) begin
                        mret_wr_d = 1'b1;
                        target_d  = mepc & ~32'h0000_0003;
                    end else begin
                        trap_wr_d = 1'b1;
                        cause_d   = arb_cause_s;
                        epc_d     = arb_epc_s;
                        tval_d    = arb_tval_s;
                        target_d  = handler_target(mtvec, arb_is_irq_s, arb_cause_s[3:0]);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flush_d    = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        redir_d    = (state_d == ST_REDIRECT);
        redir_pc_d = redir_d ? target_d : 32'd0;
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            tval_q     <= 32'd0;
            target_q   <= 32'd0;
            trap_wr_q  <= 1'b0;
            mret_wr_q  <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            redir_q    <= 1'b0;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            target_q   <= target_d;
            trap_wr_q  <= trap_wr_d;
            mret_wr_q  <= mret_wr_d;
            flush_q    <= flush_d;
            busy_q     <= busy_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign flush          = flush_q;
    assign busy           = busy_q;
    assign trap_wr        = trap_wr_q;
    assign mret_wr        = mret_wr_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign trap_tval      = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed scenarios plus random requests
// predicted by a reference model of the trap-priority rules.
module tb_trap_ctrl;

    localparam int F = 2;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic [2:0]  irq_pending;
    logic [2:0]  irq_enable;
    logic        mstatus_mie;
    logic        retire;
    logic [31:0] next_pc;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_wr;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret_wr;
    logic        busy;

    trap_ctrl #(.FLUSH_CYCLES(F), .RESET_VEC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .irq_pending(irq_pending), .irq_enable(irq_enable), .mstatus_mie(mstatus_mie),
        .retire(retire), .next_pc(next_pc), .mret(mret), .mtvec(mtvec), .mepc(mepc),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_wr(trap_wr), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_tval(trap_tval), .mret_wr(mret_wr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_mret;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] target;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mdl_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a trap controller in IDLE should accept right now.
    function automatic bit predict(output exp_t e);
        int          irq_code[3] = '{11, 3, 7};
        int          irq_bit[3]  = '{2, 0, 1};
        logic [31:0] base;
        base     = {mtvec[31:2], 2'b00};
        e.is_mret = 1'b0;
        e.cause   = 32'd0;
        e.epc     = 32'd0;
        e.tval    = 32'd0;
        e.target  = 32'd0;
        if (exc_valid) begin
            e.cause  = {28'd0, exc_code};
            e.epc    = exc_pc;
            e.tval   = exc_tval;
            e.target = base;
            return 1'b1;
        end
        if (retire && mstatus_mie) begin
            for (int k = 0; k < 3; k++) begin
                if (irq_pending[irq_bit[k]] && irq_enable[irq_bit[k]]) begin
                    e.cause  = 32'h8000_0000 + 32'(irq_code[k]);
                    e.epc    = next_pc;
                    e.target = base + ((mtvec[1:0] == 2'd1) ? 32'(4 * irq_code[k]) : 32'd0);
                    return 1'b1;
                end
            end
        end
        if (mret) begin
            e.is_mret = 1'b1;
            e.target  = mepc & ~32'h0000_0003;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_in();
        exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0; exc_tval = 32'd0;
        irq_pending = 3'd0; irq_enable = 3'd0; mstatus_mie = 1'b0; retire = 1'b0;
        next_pc = 32'd0; mret = 1'b0; mtvec = 32'd0; mepc = 32'd0;
    endtask

    // Present current inputs for one cycle, recording any expected acceptance.
    task automatic step();
        exp_t e;
        if (mdl_busy == 0) begin
            if (predict(e)) begin
                sb_q.push_back(e);
                mdl_busy = F + 1;
            end
        end else begin
            mdl_busy--;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each write strobe, then checks the redirect.
    exp_t pend;
    bit   pend_valid = 1'b0;
    int   cyc = 0;
    int   pend_cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend_valid = 1'b0;
        end else begin
            if (redirect_valid) begin
                if (!pend_valid) begin
                    chk("redirect_unexpected", {31'd0, redirect_valid}, 32'd0);
                end else begin
                    chk("redirect_pc", redirect_pc, pend.target);
                    chk("redirect_latency", 32'(cyc - pend_cyc), 32'(F));
                    chk("redirect_flush", {31'd0, flush}, 32'd1);
                    if (!pend.is_mret) chk("cause_held", trap_cause, pend.cause);
                    pend_valid = 1'b0;
                end
            end else if (redirect_pc != 32'd0) begin
                chk("redirect_pc_idle", redirect_pc, 32'd0);
            end
            if (trap_wr || mret_wr) begin
                if (sb_q.size() == 0) begin
                    chk("write_unexpected", {31'd0, trap_wr | mret_wr}, 32'd0);
                end else begin
                    pend = sb_q.pop_front();
                    chk("trap_wr", {31'd0, trap_wr}, {31'd0, ~pend.is_mret});
                    chk("mret_wr", {31'd0, mret_wr}, {31'd0, pend.is_mret});
                    chk("busy_on_wr", {31'd0, busy}, 32'd1);
                    if (!pend.is_mret) begin
                        chk("trap_cause", trap_cause, pend.cause);
                        chk("trap_epc", trap_epc, pend.epc);
                        chk("trap_tval", trap_tval, pend.tval);
                    end
                    pend_valid = 1'b1;
                    pend_cyc   = cyc;
                end
            end
            if (pend_valid && (cyc - pend_cyc > F + 2)) begin
                chk("redirect_timeout", {31'd0, redirect_valid}, 32'd1);
                pend_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_trap_wr", {31'd0, trap_wr}, 32'd0);
        chk("rst_mret_wr", {31'd0, mret_wr}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_cause", trap_cause, 32'd0);
        chk("rst_epc", trap_epc, 32'd0);
        chk("rst_tval", trap_tval, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b1;
        step();

        // Illegal instruction.
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h100; exc_tval = 32'h13; mtvec = 32'h8000_0001;
        step(); clear_in(); repeat (5) step();

        // Vectored timer interrupt.
        retire = 1'b1; mstatus_mie = 1'b1; irq_pending = 3'b010; irq_enable = 3'b010;
        next_pc = 32'h204; mtvec = 32'h8000_0001;
        step(); clear_in(); repeat (5) step();

        // All interrupts pending, then the same with an ecall alongside.
        retire = 1'b1; mstatus_mie = 1'b1; irq_pending = 3'b111; irq_enable = 3'b111;
        next_pc = 32'h300; mtvec = 32'h4000_0001;
        step(); clear_in(); repeat (5) step();
        retire = 1'b1; mstatus_mie = 1'b1; irq_pending = 3'b111; irq_enable = 3'b111;
        exc_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h310; mtvec = 32'h4000_0001;
        step(); clear_in(); repeat (5) step();

        // MSI beats MTI.
        retire = 1'b1; mstatus_mie = 1'b1; irq_pending = 3'b011; irq_enable = 3'b111;
        next_pc = 32'h400; mtvec = 32'h1000_0001;
        step(); clear_in(); repeat (5) step();

        // mret, then mret colliding with an exception.
        mret = 1'b1; mepc = 32'h0000_0207;
        step(); clear_in(); repeat (5) step();
        mret = 1'b1; mepc = 32'h0000_0207; exc_valid = 1'b1; exc_code = 4'd4;
        exc_pc = 32'h500; exc_tval = 32'hDEAD_BEEF; mtvec = 32'h2000_0000;
        step(); clear_in(); repeat (5) step();

        // Masked interrupt: globally disabled, then not at retire, then taken.
        irq_pending = 3'b100; irq_enable = 3'b111; retire = 1'b1; mstatus_mie = 1'b0;
        next_pc = 32'h600; mtvec = 32'h3000_0001;
        step();
        chk("masked_mie_busy", {31'd0, busy}, 32'd0);
        mstatus_mie = 1'b1; retire = 1'b0;
        step();
        chk("masked_retire_busy", {31'd0, busy}, 32'd0);
        chk("masked_retire_flush", {31'd0, flush}, 32'd0);
        retire = 1'b1;
        step();
        chk("unmasked_busy", {31'd0, busy}, 32'd1);
        clear_in(); repeat (5) step();

        // Reset in the middle of a flush.
        exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h700; exc_tval = 32'h1234; mtvec = 32'h5000_0000;
        step(); clear_in();
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_flush", {31'd0, flush}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_trap_wr", {31'd0, trap_wr}, 32'd0);
        chk("rstmid_redirect", {31'd0, redirect_valid}, 32'd0);
        sb_q.delete();
        mdl_busy = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel         = $urandom_range(8, 0);
            exc_valid   = ($urandom_range(7, 0) == 0);
            exc_code    = (sel == 8) ? 4'd11 : 4'(sel);
            exc_pc      = $urandom;
            exc_tval    = $urandom;
            irq_pending = 3'($urandom);
            irq_enable  = 3'($urandom);
            mstatus_mie = 1'($urandom);
            retire      = 1'($urandom);
            next_pc     = $urandom;
            mret        = ($urandom_range(7, 0) == 0);
            mtvec       = $urandom;
            mepc        = $urandom;
            step();
        end
        clear_in();
        repeat (10) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("redirect_drained", {31'd0, pend_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
